// File: rtl/mem_rt_arbiter.sv
// Request arbiter/sequencer in front of banked main memory: per-cycle conflict-free
// grant set (one per thread group), fixed 3-cycle issue/return pipeline, MC read with bounded wait.
module mem_rt_arbiter #(
    parameter int NUM_RT      = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int GRP_LSB     = 14,
    parameter int GRP_W       = 4,
    parameter int MC_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RT-1:0] req_RT,
    input  logic [NUM_RT-1:0] we_RT,
    input  logic [ADDR_W-1:0] addr_RT     [NUM_RT],
    input  logic [DATA_W-1:0] data_RT_in  [NUM_RT],
    output logic [NUM_RT-1:0] rdy_RT,
    output logic [DATA_W-1:0] data_RT_out [NUM_RT],
    input  logic              re_MC,
    input  logic [ADDR_W-1:0] addr_MC,
    output logic              rdy_MC,
    output logic [DATA_W-1:0] data_MC_out,
    output logic [NUM_RT-1:0] mem_we,
    output logic [ADDR_W-1:0] mem_addr    [NUM_RT],
    output logic [DATA_W-1:0] mem_din     [NUM_RT],
    input  logic [DATA_W-1:0] mem_dout    [NUM_RT],
    output logic              mem_re_MC,
    output logic [ADDR_W-1:0] mem_addr_MC,
    input  logic [DATA_W-1:0] mem_dout_MC
);

    localparam int PTR_W   = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;
    localparam int WAIT_W  = $clog2(MC_MAX_WAIT + 1);
    localparam int NUM_GRP = 1 << GRP_W;

    logic [PTR_W-1:0]   rr_ptr;
    logic [WAIT_W-1:0]  mc_wait;
    logic [NUM_RT-1:0]  inflight;
    logic               mc_inflight;
    logic [NUM_RT-1:0]  st1_v, st1_rd, st2_v, st2_rd;
    logic               mc_st2;

    logic [NUM_RT-1:0]  elig;
    logic [NUM_RT-1:0]  scan_grant;
    logic [NUM_RT-1:0]  rt_grant;
    logic               scan_deny;
    logic               rr_adv;
    logic               mc_grant;
    logic [NUM_GRP-1:0] taken;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   idx;
    logic [GRP_W-1:0]   grp;

    always_comb begin
        elig       = req_RT & ~inflight;
        mc_grant   = re_MC && !mc_inflight &&
                     ((elig == '0) || (mc_wait == WAIT_W'(MC_MAX_WAIT)));
        taken      = '0;
        scan_grant = '0;
        scan_deny  = 1'b0;
        scan_sum   = '0;
        idx        = '0;
        grp        = '0;
        // Round-robin scan: first port seen in a group wins, later ones in the same group lose.
        for (int k = 0; k < NUM_RT; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_RT))
                idx = PTR_W'(scan_sum - (PTR_W+1)'(NUM_RT));
            else
                idx = PTR_W'(scan_sum);
            grp = addr_RT[idx][GRP_LSB +: GRP_W];
            if (elig[idx]) begin
                if (taken[grp]) begin
                    scan_deny = 1'b1;
                end else begin
                    taken[grp]      = 1'b1;
                    scan_grant[idx] = 1'b1;
                end
            end
        end
        rt_grant = mc_grant ? '0 : scan_grant;
        rr_adv   = scan_deny && !mc_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            mc_wait     <= '0;
            inflight    <= '0;
            mc_inflight <= 1'b0;
            st1_v       <= '0;
            st1_rd      <= '0;
            st2_v       <= '0;
            st2_rd      <= '0;
            mc_st2      <= 1'b0;
            rdy_RT      <= '0;
            rdy_MC      <= 1'b0;
            data_MC_out <= '0;
            mem_we      <= '0;
            mem_re_MC   <= 1'b0;
            mem_addr_MC <= '0;
            for (int i = 0; i < NUM_RT; i++) begin
                mem_addr[i]    <= '0;
                mem_din[i]     <= '0;
                data_RT_out[i] <= '0;
            end
        end else begin
            if (rr_adv)
                rr_ptr <= (rr_ptr == PTR_W'(NUM_RT-1)) ? '0 : rr_ptr + 1'b1;

            // Only time spent actually waiting for a grant counts toward the MC bound.
            if (mc_grant)
                mc_wait <= '0;
            else if (re_MC && !mc_inflight && (mc_wait != WAIT_W'(MC_MAX_WAIT)))
                mc_wait <= mc_wait + 1'b1;

            inflight    <= (inflight & ~rdy_RT) | rt_grant;
            mc_inflight <= (mc_inflight & ~rdy_MC) | mc_grant;

            mem_we <= rt_grant & we_RT;
            st1_v  <= rt_grant;
            st1_rd <= rt_grant & ~we_RT;
            st2_v  <= st1_v;
            st2_rd <= st1_rd;
            rdy_RT <= st2_v;

            for (int i = 0; i < NUM_RT; i++) begin
                if (rt_grant[i]) begin
                    mem_addr[i] <= addr_RT[i];
                    mem_din[i]  <= data_RT_in[i];
                end
                data_RT_out[i] <= st2_rd[i] ? mem_dout[i] : '0;
            end

            mem_re_MC <= mc_grant;
            if (mc_grant)
                mem_addr_MC <= addr_MC;
            mc_st2      <= mem_re_MC;
            rdy_MC      <= mc_st2;
            data_MC_out <= mc_st2 ? mem_dout_MC : '0;
        end
    end

endmodule

// File: tb/tb_mem_rt_arbiter.sv
// Directed bench for mem_rt_arbiter with a tagged behavioural memory behind the
// RT and MC ports; expectations are hand-computed cycle by cycle.
module tb_mem_rt_arbiter;

    localparam int NUM_RT = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_RT-1:0] req_RT, we_RT;
    logic [ADDR_W-1:0] addr_RT     [NUM_RT];
    logic [DATA_W-1:0] data_RT_in  [NUM_RT];
    logic [NUM_RT-1:0] rdy_RT;
    logic [DATA_W-1:0] data_RT_out [NUM_RT];
    logic              re_MC;
    logic [ADDR_W-1:0] addr_MC;
    logic              rdy_MC;
    logic [DATA_W-1:0] data_MC_out;
    logic [NUM_RT-1:0] mem_we;
    logic [ADDR_W-1:0] mem_addr    [NUM_RT];
    logic [DATA_W-1:0] mem_din     [NUM_RT];
    logic [DATA_W-1:0] mem_dout    [NUM_RT];
    logic              mem_re_MC;
    logic [ADDR_W-1:0] mem_addr_MC;
    logic [DATA_W-1:0] mem_dout_MC;

    always #5 clk = ~clk;

    mem_rt_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_RT(req_RT), .we_RT(we_RT), .addr_RT(addr_RT), .data_RT_in(data_RT_in),
        .rdy_RT(rdy_RT), .data_RT_out(data_RT_out),
        .re_MC(re_MC), .addr_MC(addr_MC), .rdy_MC(rdy_MC), .data_MC_out(data_MC_out),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_re_MC(mem_re_MC), .mem_addr_MC(mem_addr_MC), .mem_dout_MC(mem_dout_MC)
    );

    // Unwritten locations return an address-derived pattern; writes are tagged.
    logic [DATA_W-1:0] mem_arr [256];
    logic [ADDR_W-1:0] mem_tag [256];
    bit                mem_val [256];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    function automatic logic [7:0] hsh(input logic [ADDR_W-1:0] a);
        return a[11:4] ^ a[21:14];
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        if (mem_val[hsh(a)] && mem_tag[hsh(a)] == a)
            return mem_arr[hsh(a)];
        return pat(a);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NUM_RT; i++) begin
            if (mem_we[i]) begin
                mem_arr[hsh(mem_addr[i])] <= mem_din[i];
                mem_tag[hsh(mem_addr[i])] <= mem_addr[i];
                mem_val[hsh(mem_addr[i])] <= 1'b1;
            end
            mem_dout[i] <= rd(mem_addr[i]);
        end
        mem_dout_MC <= rd(mem_addr_MC);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [NUM_RT-1:0] exp_rdy [4];
    int                exp_idx [4];
    logic [DATA_W-1:0] wdata;

    initial begin
        rst_n   = 1'b0;
        req_RT  = '0;
        we_RT   = '0;
        re_MC   = 1'b0;
        addr_MC = '0;
        for (int i = 0; i < NUM_RT; i++) begin
            addr_RT[i]    = '0;
            data_RT_in[i] = '0;
        end

        idle(2);
        check("rst_rdy_rt", rdy_RT, 0);
        check("rst_rdy_mc", rdy_MC, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re_mc", mem_re_MC, 0);
        check("rst_mem_addr0", mem_addr[0], 0);
        check("rst_data_rt0", data_RT_out[0], 0);
        rst_n = 1'b1;
        idle(1);

        // Single RT0 read
        addr_RT[0] = 32'h0000_4010;
        req_RT     = 4'b0001;
        idle(1);
        check("rd1_mem_we", mem_we, 0);
        check("rd1_mem_addr", mem_addr[0], 32'h0000_4010);
        idle(1);
        check("rd1_rdy_early", rdy_RT, 0);
        idle(1);
        check("rd1_rdy", rdy_RT, 4'b0001);
        check("rd1_data", data_RT_out[0], pat(32'h0000_4010));
        req_RT = '0;
        idle(1);
        check("rd1_rdy_pulse", rdy_RT, 0);
        idle(2);

        // Four writes to distinct groups issue together
        for (int i = 0; i < NUM_RT; i++) begin
            addr_RT[i]    = (i << 14) | (i * 256);
            data_RT_in[i] = {4{32'h1111_1111 * (i + 1)}};
        end
        we_RT  = 4'hF;
        req_RT = 4'hF;
        idle(1);
        check("wr4_mem_we", mem_we, 4'hF);
        check("wr4_mem_addr2", mem_addr[2], 32'h0000_8200);
        check("wr4_mem_din3", mem_din[3], {4{32'h4444_4444}});
        idle(2);
        check("wr4_rdy", rdy_RT, 4'hF);
        check("wr4_data1", data_RT_out[1], 0);
        req_RT = '0;
        we_RT  = '0;
        idle(3);

        // All four in group 5 from rr_ptr=0: serialised 0,1,2,3
        for (int i = 0; i < NUM_RT; i++) addr_RT[i] = 32'h0001_4000 + i * 16;
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_idx = '{0, 1, 2, 3};
        req_RT = 4'hF;
        for (int c = 1; c <= 6; c++) begin
            idle(1);
            if (c == 1) check("g5_first_addr", mem_addr[0], 32'h0001_4000);
            if (c >= 3) begin
                check($sformatf("g5_rdy_c%0d", c), rdy_RT, exp_rdy[c-3]);
                check($sformatf("g5_data_c%0d", c), data_RT_out[exp_idx[c-3]],
                      pat(32'h0001_4000 + exp_idx[c-3] * 16));
                req_RT = req_RT & ~exp_rdy[c-3];
            end
        end
        idle(3);

        // Three denial cycles left rr_ptr at 3: group 6 serialises 3,0,1,2
        for (int i = 0; i < NUM_RT; i++) addr_RT[i] = 32'h0001_8000 + i * 16;
        exp_rdy = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        exp_idx = '{3, 0, 1, 2};
        req_RT = 4'hF;
        for (int c = 1; c <= 6; c++) begin
            idle(1);
            if (c >= 3) begin
                check($sformatf("g6_rdy_c%0d", c), rdy_RT, exp_rdy[c-3]);
                check($sformatf("g6_data_c%0d", c), data_RT_out[exp_idx[c-3]],
                      pat(32'h0001_8000 + exp_idx[c-3] * 16));
                req_RT = req_RT & ~exp_rdy[c-3];
            end
        end
        idle(3);

        // Staggered RT traffic keeps someone eligible every cycle; MC forced in at mc_wait==8
        for (int i = 0; i < NUM_RT; i++) addr_RT[i] = (i + 8) << 14;
        addr_MC = 32'h0000_7000;
        for (int c = 0; c < 14; c++) begin
            if (c == 3)  check("mc_rdy_rt0_c3", rdy_RT, 4'b0001);
            if (c == 8)  check("mc_not_early", mem_re_MC, 0);
            if (c == 9) begin
                check("mc_issue", mem_re_MC, 1);
                check("mc_issue_addr", mem_addr_MC, 32'h0000_7000);
            end
            if (c == 10) check("mc_rdy_rt_c10", rdy_RT, 4'b1000);
            if (c == 11) begin
                check("mc_rdy", rdy_MC, 1);
                check("mc_data", data_MC_out, pat(32'h0000_7000));
                check("mc_no_rt_grant", rdy_RT, 0);
                re_MC = 1'b0;
            end
            if (c == 12) begin
                check("mc_rdy_rt_c12", rdy_RT, 4'b0011);
                check("mc_rdy_pulse", rdy_MC, 0);
            end
            if (c == 0) re_MC = 1'b1;
            if (c < NUM_RT) req_RT[c] = 1'b1;
            idle(1);
        end
        req_RT = '0;
        idle(6);

        // Reset while an RT2 write is on the memory port
        addr_RT[2]    = 32'h0002_8000;
        data_RT_in[2] = {4{32'hCAFE_F00D}};
        we_RT         = 4'b0100;
        req_RT        = 4'b0100;
        idle(1);
        check("rst_wr_staged", mem_we, 4'b0100);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr_abort", mem_we, 0);
        check("rst_wr_addr", mem_addr[2], 0);
        check("rst_wr_din", mem_din[2], 0);
        check("rst_wr_rdy", rdy_RT, 0);
        req_RT = '0;
        we_RT  = '0;
        idle(2);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle(1);
            check($sformatf("rst_no_rdy_c%0d", c), rdy_RT, 0);
        end

        // Read after write on RT1
        wdata         = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        addr_RT[1]    = 32'h0000_8020;
        data_RT_in[1] = wdata;
        we_RT         = 4'b0010;
        req_RT        = 4'b0010;
        idle(3);
        check("raw_wr_rdy", rdy_RT, 4'b0010);
        req_RT = '0;
        we_RT  = '0;
        idle(1);
        req_RT = 4'b0010;
        idle(3);
        check("raw_rd_rdy", rdy_RT, 4'b0010);
        check("raw_rd_data", data_RT_out[1], wdata);
        req_RT = '0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
